// File: rtl/eth_phy_10g_prbs31_checker.sv
// Receive-side PRBS31 checker for the 10GBASE-R PHY.
// Three-stage pipeline: block capture, parallel error detection with
// self-synchronising history, then lock FSM and saturating error counter.
module eth_phy_10g_prbs31_checker #(
    parameter int ERR_CNT_WIDTH = 16,
    parameter int LOCK_CNT      = 64,
    parameter int UNLOCK_CNT    = 4,
    parameter int BAD_THRESH    = 8
) (
    input  logic                     rx_clk,
    input  logic                     rx_rst_n,
    input  logic [63:0]              serdes_rx_data,
    input  logic [1:0]               serdes_rx_hdr,
    input  logic                     serdes_rx_valid,
    input  logic                     cfg_rx_prbs31_enable,
    input  logic                     err_count_clr,
    output logic                     rx_prbs_locked,
    output logic [ERR_CNT_WIDTH-1:0] rx_prbs_err_count,
    output logic                     rx_prbs_err_block
);

    localparam int LC_W  = $clog2(LOCK_CNT + 1);
    localparam int UC_W  = $clog2(UNLOCK_CNT + 1);
    localparam int SUM_W = ((ERR_CNT_WIDTH > 7) ? ERR_CNT_WIDTH : 7) + 1;
    localparam logic [6:0] BAD_TH = 7'(BAD_THRESH);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // ---------------- stage 0: block capture ----------------
    // Serial order is bit 0 first: hdr[0], hdr[1], data[0] .. data[63].
    logic [65:0] blk_q;
    logic        vld0_q;

    // Capture a block only when qualified; valid travels with it.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            blk_q  <= '0;
            vld0_q <= 1'b0;
        end else begin
            vld0_q <= serdes_rx_valid;
            if (serdes_rx_valid) begin
                blk_q <= {serdes_rx_data, serdes_rx_hdr};
            end
        end
    end

    // ---------------- stage 1: error detection ----------------
    // seq[0..30] is the stored history (oldest first), seq[31+j] is the
    // de-inverted received bit j. Because history is always taken from
    // received bits, every prediction depends only on seq, so all 66
    // bits resolve in parallel.
    logic [30:0] hist_q;
    logic [30:0] hist_d;
    logic [96:0] seq;
    logic [65:0] err_vec;
    logic [6:0]  e_d;
    logic [6:0]  e_q;
    logic        hist_nz_q;
    logic        vld1_q;

    genvar gi;
    generate
        for (gi = 0; gi < 31; gi++) begin : g_hist_in
            assign seq[gi] = hist_q[30-gi];
        end
        for (gi = 0; gi < 66; gi++) begin : g_bit
            assign seq[31+gi]  = ~blk_q[gi];
            assign err_vec[gi] = seq[gi+3] ^ seq[gi] ^ seq[31+gi];
        end
        for (gi = 0; gi < 31; gi++) begin : g_hist_out
            // hist_d[0] is the newest bit of the block
            assign hist_d[gi] = seq[96-gi];
        end
    endgenerate

    // Per-block error popcount.
    always_comb begin
        e_d = '0;
        for (int i = 0; i < 66; i++) begin
            e_d = e_d + {6'd0, err_vec[i]};
        end
    end

    // Register error count and new history; invalid blocks leave history alone.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            hist_q    <= '0;
            e_q       <= '0;
            hist_nz_q <= 1'b0;
            vld1_q    <= 1'b0;
        end else begin
            vld1_q <= vld0_q;
            if (vld0_q) begin
                hist_q    <= hist_d;
                e_q       <= e_d;
                hist_nz_q <= |hist_d;
            end
        end
    end

    // ---------------- stage 2: lock FSM and counters ----------------
    state_t                   state_q, state_d;
    logic [LC_W-1:0]          clean_cnt_q, clean_cnt_d;
    logic [UC_W-1:0]          bad_cnt_q, bad_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     err_blk_q, err_blk_d;
    logic [ERR_CNT_WIDTH-1:0] err_base;
    logic [SUM_W-1:0]         err_sum;
    logic                     blk_clean;
    logic                     blk_bad;

    // An all-zero de-inverted history (stuck-ones line) never counts as clean.
    assign blk_clean = (e_q == 7'd0) && hist_nz_q;
    assign blk_bad   = (e_q >= BAD_TH);
    // Clear applies before the accumulate of the same edge.
    assign err_base  = err_count_clr ? '0 : err_cnt_q;
    assign err_sum   = SUM_W'(err_base) + SUM_W'(e_q);

    // Next-state, block counters and error accumulation.
    always_comb begin
        state_d     = state_q;
        clean_cnt_d = clean_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        err_cnt_d   = err_base;
        err_blk_d   = 1'b0;
        if (!cfg_rx_prbs31_enable) begin
            state_d     = HUNT;
            clean_cnt_d = '0;
            bad_cnt_d   = '0;
        end else if (vld1_q) begin
            case (state_q)
                HUNT: begin
                    if (!blk_clean) begin
                        clean_cnt_d = '0;
                    end else if (clean_cnt_q == LC_W'(LOCK_CNT - 1)) begin
                        state_d     = LOCKED;
                        clean_cnt_d = '0;
                    end else begin
                        clean_cnt_d = clean_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    err_blk_d = (e_q != 7'd0);
                    if (|err_sum[SUM_W-1:ERR_CNT_WIDTH]) begin
                        err_cnt_d = '1;
                    end else begin
                        err_cnt_d = err_sum[ERR_CNT_WIDTH-1:0];
                    end
                    if (!blk_bad) begin
                        bad_cnt_d = '0;
                    end else if (bad_cnt_q == UC_W'(UNLOCK_CNT - 1)) begin
                        state_d   = HUNT;
                        bad_cnt_d = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q     <= HUNT;
            clean_cnt_q <= '0;
            bad_cnt_q   <= '0;
            err_cnt_q   <= '0;
            err_blk_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clean_cnt_q <= clean_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_blk_q   <= err_blk_d;
        end
    end

    assign rx_prbs_locked    = (state_q == LOCKED);
    assign rx_prbs_err_count = err_cnt_q;
    assign rx_prbs_err_block = err_blk_q;

endmodule

// File: tb/tb_eth_phy_10g_prbs31_checker.sv
// Directed bench for the PRBS31 checker: lock, error injection,
// saturation/clear, unlock/relock, stuck line, valid gaps, reset, disable.
module tb_eth_phy_10g_prbs31_checker;

    logic        rx_clk = 1'b0;
    logic        rx_rst_n = 1'b0;
    logic [63:0] serdes_rx_data = '0;
    logic [1:0]  serdes_rx_hdr = '0;
    logic        serdes_rx_valid = 1'b0;
    logic        cfg_rx_prbs31_enable = 1'b0;
    logic        err_count_clr = 1'b0;
    logic        rx_prbs_locked;
    logic [3:0]  rx_prbs_err_count;
    logic        rx_prbs_err_block;

    int n_vec  = 0;
    int n_miss = 0;

    // TX-side generator state: gen_state[k] = b[n-1-k]
    logic [30:0] gen_state = 31'h5A5A1234;

    eth_phy_10g_prbs31_checker #(
        .ERR_CNT_WIDTH(4),
        .LOCK_CNT(64),
        .UNLOCK_CNT(4),
        .BAD_THRESH(8)
    ) dut (
        .rx_clk(rx_clk),
        .rx_rst_n(rx_rst_n),
        .serdes_rx_data(serdes_rx_data),
        .serdes_rx_hdr(serdes_rx_hdr),
        .serdes_rx_valid(serdes_rx_valid),
        .cfg_rx_prbs31_enable(cfg_rx_prbs31_enable),
        .err_count_clr(err_count_clr),
        .rx_prbs_locked(rx_prbs_locked),
        .rx_prbs_err_count(rx_prbs_err_count),
        .rx_prbs_err_block(rx_prbs_err_block)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end else begin
            $display("chk %s: observed %0d ok", tag, obs);
        end
    endtask

    // Next 66 line bits from the TX generator (inverted on the line).
    task automatic prbs_block(output logic [1:0] h, output logic [63:0] d);
        logic [65:0] blk;
        logic        b;
        for (int j = 0; j < 66; j++) begin
            b         = gen_state[27] ^ gen_state[30];
            gen_state = {gen_state[29:0], b};
            blk[j]    = ~b;
        end
        h = blk[1:0];
        d = blk[65:2];
    endtask

    task automatic send_blk(input logic [1:0] h, input logic [63:0] d, input logic v);
        serdes_rx_hdr   = h;
        serdes_rx_data  = d;
        serdes_rx_valid = v;
        @(posedge rx_clk);
        #1;
    endtask

    // One PRBS block; flip >= 0 inverts that data bit.
    task automatic send_prbs(input int flip);
        logic [1:0]  h;
        logic [63:0] d;
        prbs_block(h, d);
        if (flip >= 0) d[flip] = ~d[flip];
        send_blk(h, d, 1'b1);
    endtask

    task automatic send_rand(input logic v);
        send_blk(2'($urandom), {$urandom, $urandom}, v);
    endtask

    // Send n PRBS blocks; lock must appear exactly two edges after the last.
    task automatic lock_run(input string tag, input int n);
        for (int i = 0; i < n; i++) send_prbs(-1);
        check_val({tag, "_n0"}, 32'(rx_prbs_locked), 32'd0);
        send_prbs(-1);
        check_val({tag, "_n1"}, 32'(rx_prbs_locked), 32'd0);
        send_prbs(-1);
        check_val({tag, "_n2"}, 32'(rx_prbs_locked), 32'd1);
    endtask

    initial begin
        int exp_cnt;

        // reset state
        repeat (3) @(posedge rx_clk);
        #1;
        check_val("rst_locked", 32'(rx_prbs_locked), 32'd0);
        check_val("rst_count", 32'(rx_prbs_err_count), 32'd0);
        check_val("rst_errblk", 32'(rx_prbs_err_block), 32'd0);
        rx_rst_n = 1'b1;
        cfg_rx_prbs31_enable = 1'b1;

        // lock acquisition: block 1 sees zero history, blocks 2..65 are the 64 clean ones
        lock_run("lock", 65);
        check_val("lock_count", 32'(rx_prbs_err_count), 32'd0);

        // single flipped bit: errors at stream bits 12, 40, 43 of one block
        send_prbs(10);
        send_prbs(-1);
        send_prbs(-1);
        check_val("flip_errblk", 32'(rx_prbs_err_block), 32'd1);
        check_val("flip_count", 32'(rx_prbs_err_count), 32'd3);
        check_val("flip_locked", 32'(rx_prbs_locked), 32'd1);
        send_prbs(-1);
        check_val("flip_errblk_end", 32'(rx_prbs_err_block), 32'd0);

        // saturation of the 4-bit counter
        exp_cnt = 3;
        for (int k = 0; k < 5; k++) begin
            send_prbs(10);
            send_prbs(-1);
            send_prbs(-1);
            exp_cnt = (exp_cnt + 3 > 15) ? 15 : exp_cnt + 3;
            check_val("sat_count", 32'(rx_prbs_err_count), 32'(exp_cnt));
        end

        // clear coinciding with a 3-error accumulate
        send_prbs(10);
        send_prbs(-1);
        err_count_clr = 1'b1;
        send_prbs(-1);
        err_count_clr = 1'b0;
        check_val("clr_accum", 32'(rx_prbs_err_count), 32'd3);

        // unlock on 4 random blocks
        repeat (4) send_rand(1'b1);
        send_prbs(-1);
        check_val("unlock_n1", 32'(rx_prbs_locked), 32'd1);
        send_prbs(-1);
        check_val("unlock_n2", 32'(rx_prbs_locked), 32'd0);
        check_val("unlock_count", 32'(rx_prbs_err_count), 32'd15);

        // relock: first restored block dirty, 64 clean follow (2 already sent)
        lock_run("relock", 63);
        check_val("relock_count", 32'(rx_prbs_err_count), 32'd15);

        // plain clear, then two flips for a non-zero count
        err_count_clr = 1'b1;
        send_prbs(-1);
        err_count_clr = 1'b0;
        check_val("clr_idle", 32'(rx_prbs_err_count), 32'd0);
        send_prbs(10);
        send_prbs(10);
        send_prbs(-1);
        send_prbs(-1);
        check_val("pre_rst_count", 32'(rx_prbs_err_count), 32'd6);

        // asynchronous reset mid-cycle
        #3;
        rx_rst_n = 1'b0;
        #1;
        check_val("arst_locked", 32'(rx_prbs_locked), 32'd0);
        check_val("arst_count", 32'(rx_prbs_err_count), 32'd0);
        check_val("arst_errblk", 32'(rx_prbs_err_block), 32'd0);
        @(negedge rx_clk);
        rx_rst_n = 1'b1;

        // stuck all-ones line must never lock
        repeat (100) send_blk(2'b11, '1, 1'b1);
        check_val("stuck_locked", 32'(rx_prbs_locked), 32'd0);

        // PRBS with valid toggling; invalid slots carry garbage
        for (int i = 0; i < 65; i++) begin
            send_prbs(-1);
            if (i == 64) check_val("gap_n0", 32'(rx_prbs_locked), 32'd0);
            send_rand(1'b0);
            if (i == 64) check_val("gap_n1", 32'(rx_prbs_locked), 32'd0);
        end
        send_prbs(-1);
        check_val("gap_n2", 32'(rx_prbs_locked), 32'd1);
        check_val("gap_count", 32'(rx_prbs_err_count), 32'd0);

        // disable while locked
        send_prbs(10);
        send_prbs(-1);
        send_prbs(-1);
        check_val("dis_pre_count", 32'(rx_prbs_err_count), 32'd3);
        cfg_rx_prbs31_enable = 1'b0;
        send_prbs(-1);
        check_val("dis_locked", 32'(rx_prbs_locked), 32'd0);
        check_val("dis_count", 32'(rx_prbs_err_count), 32'd3);
        send_prbs(-1);
        send_prbs(-1);
        send_rand(1'b0);
        send_rand(1'b0);
        cfg_rx_prbs31_enable = 1'b1;
        // history survived the disable, so every new block is clean
        lock_run("reen", 64);
        check_val("reen_count", 32'(rx_prbs_err_count), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
